// File: rtl/safety_zone_if.sv
// Bundles the safety zone monitor's sensor, operator and alarm-panel signals.
// The master side drives sensors and controls; the slave side is the monitor itself.
interface safety_zone_if #(
    parameter int NUM_ZONES = 4
);
    logic [NUM_ZONES-1:0] manual_trigger;
    logic [NUM_ZONES-1:0] loud_noise;
    logic [NUM_ZONES-1:0] carbon_sensor;
    logic [NUM_ZONES-1:0] unwanted_person;
    logic [NUM_ZONES-1:0] medical_report;
    logic                 is_raining;
    logic                 local_alert;
    logic                 is_system_test;
    logic                 all_clear;
    logic                 ack;

    logic [NUM_ZONES-1:0] zone_fire;
    logic [NUM_ZONES-1:0] zone_lockdown;
    logic [NUM_ZONES-1:0] zone_medical;
    logic                 storm;
    logic                 heightened_security;
    logic                 no_emergency;
    logic                 non_specific_emergency;
    logic                 confirmed_emergency;
    logic                 escalated;
    logic                 warn_students;
    logic                 authority_contacted;
    logic                 need_evacuation;
    logic                 lockdown_needed;
    logic                 all_clear_out;
    logic [2:0]           state;

    modport master (
        output manual_trigger, loud_noise, carbon_sensor, unwanted_person, medical_report,
        output is_raining, local_alert, is_system_test, all_clear, ack,
        input  zone_fire, zone_lockdown, zone_medical, storm, heightened_security,
        input  no_emergency, non_specific_emergency, confirmed_emergency, escalated,
        input  warn_students, authority_contacted, need_evacuation, lockdown_needed,
        input  all_clear_out, state
    );

    modport slave (
        input  manual_trigger, loud_noise, carbon_sensor, unwanted_person, medical_report,
        input  is_raining, local_alert, is_system_test, all_clear, ack,
        output zone_fire, zone_lockdown, zone_medical, storm, heightened_security,
        output no_emergency, non_specific_emergency, confirmed_emergency, escalated,
        output warn_students, authority_contacted, need_evacuation, lockdown_needed,
        output all_clear_out, state
    );
endinterface

// File: rtl/safety_zone_monitor.sv
// Multi-zone campus emergency monitor: debounced sensors, latched per-zone conditions
// and a suspect/confirmed/escalated/test/clearing sequencer with registered outputs.
module safety_zone_monitor #(
    parameter int NUM_ZONES         = 4,
    parameter int DEBOUNCE_CYCLES   = 8,
    parameter int ESCALATE_CYCLES   = 1000,
    parameter int CLEAR_HOLD_CYCLES = 16
) (
    input logic         clk,
    input logic         rst,
    safety_zone_if.slave bus
);
    localparam int NUM_RAW = 5 * NUM_ZONES + 2;
    localparam int DCW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ECW     = $clog2(ESCALATE_CYCLES + 1);
    localparam int HCW     = $clog2(CLEAR_HOLD_CYCLES + 1);

    localparam logic [DCW-1:0] DEB_SAT   = DCW'(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ECW-1:0] ESC_LAST  = ECW'(ESCALATE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(CLEAR_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SUSPECT   = 3'd1,
        CONFIRMED = 3'd2,
        ESCALATED = 3'd3,
        TEST      = 3'd4,
        CLEARING  = 3'd5
    } stateT;

    stateT stateReg, nextState;

    logic [NUM_RAW-1:0] rawVec, filtVec;
    logic               debClear;

    assign rawVec = {bus.local_alert, bus.is_raining, bus.medical_report, bus.unwanted_person,
                     bus.carbon_sensor, bus.loud_noise, bus.manual_trigger};

    // Filters are held empty while clearing so stale sensor history cannot re-trigger on return.
    assign debClear = (stateReg == CLEARING) || (nextState == CLEARING);

    generate
        for (genvar gi = 0; gi < NUM_RAW; gi++) begin : gDebounce
            logic [DCW-1:0] cnt;
            logic           filt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt  <= '0;
                    filt <= 1'b0;
                end else if (debClear || !rawVec[gi]) begin
                    cnt  <= '0;
                    filt <= 1'b0;
                end else if (cnt != DEB_SAT) begin
                    cnt  <= cnt + 1'b1;
                    filt <= (cnt == DEB_LAST);
                end
            end

            assign filtVec[gi] = filt;
        end
    endgenerate

    logic [NUM_ZONES-1:0] fManual, fLoud, fCarbon, fUnwanted, fMedical;
    logic [NUM_ZONES-1:0] trig, fireCond, lockCond;
    logic                 fRain, fLocal, stormCond, anyCond;

    assign fManual   = filtVec[0 +: NUM_ZONES];
    assign fLoud     = filtVec[NUM_ZONES +: NUM_ZONES];
    assign fCarbon   = filtVec[2*NUM_ZONES +: NUM_ZONES];
    assign fUnwanted = filtVec[3*NUM_ZONES +: NUM_ZONES];
    assign fMedical  = filtVec[4*NUM_ZONES +: NUM_ZONES];
    assign fRain     = filtVec[5*NUM_ZONES];
    assign fLocal    = filtVec[5*NUM_ZONES+1];

    assign trig      = fManual | fLoud;
    assign fireCond  = trig & fCarbon;
    assign lockCond  = {NUM_ZONES{fLocal}} & (fLoud | fUnwanted);
    assign stormCond = (|trig) & fRain;
    assign anyCond   = (|fireCond) | stormCond | (|lockCond) | (|fMedical);

    logic [NUM_ZONES-1:0] zoneFireReg, zoneLockReg, zoneMedReg;
    logic                 stormReg, hsReg;
    logic                 noEmReg, nonSpecReg, confReg, escReg;
    logic                 warnReg, authReg, evacReg, lockNeedReg, clearOutReg;
    logic [ECW-1:0]       escCnt;
    logic                 ackedReg;
    logic [HCW-1:0]       holdCnt;
    logic                 escTerminal;

    // An ack arriving on the terminal cycle suppresses escalation.
    assign escTerminal = (stateReg == CONFIRMED) && !ackedReg && !bus.ack && (escCnt == ESC_LAST);

    always_comb begin
        nextState = stateReg;
        case (stateReg)
            IDLE: begin
                if (anyCond)    nextState = bus.is_system_test ? TEST : CONFIRMED;
                else if (|trig) nextState = SUSPECT;
            end
            SUSPECT: begin
                if (bus.all_clear) nextState = CLEARING;
                else if (anyCond)  nextState = bus.is_system_test ? TEST : CONFIRMED;
            end
            CONFIRMED: begin
                if (bus.all_clear)     nextState = CLEARING;
                else if (escTerminal)  nextState = ESCALATED;
            end
            ESCALATED: begin
                if (bus.all_clear) nextState = CLEARING;
            end
            TEST: begin
                if (bus.all_clear || !bus.is_system_test) nextState = CLEARING;
            end
            CLEARING: begin
                if (holdCnt == HOLD_LAST) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    logic [NUM_ZONES-1:0] fireNext, lockNext, medNext;
    logic                 stormNext, hsNext, setPhase, confNext;

    always_comb begin
        setPhase  = (nextState == SUSPECT) || (nextState == CONFIRMED) ||
                    (nextState == ESCALATED) || (nextState == TEST);
        confNext  = (nextState == CONFIRMED) || (nextState == ESCALATED);
        fireNext  = zoneFireReg;
        lockNext  = zoneLockReg;
        medNext   = zoneMedReg;
        stormNext = stormReg;
        hsNext    = hsReg;
        if (nextState == CLEARING) begin
            fireNext  = '0;
            lockNext  = '0;
            medNext   = '0;
            stormNext = 1'b0;
            hsNext    = 1'b0;
        end else begin
            if (setPhase) begin
                fireNext  = zoneFireReg | fireCond;
                lockNext  = zoneLockReg | lockCond;
                medNext   = zoneMedReg | fMedical;
                stormNext = stormReg | stormCond;
            end
            hsNext = hsReg | fLocal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg    <= IDLE;
            zoneFireReg <= '0;
            zoneLockReg <= '0;
            zoneMedReg  <= '0;
            stormReg    <= 1'b0;
            hsReg       <= 1'b0;
            noEmReg     <= 1'b1;
            nonSpecReg  <= 1'b0;
            confReg     <= 1'b0;
            escReg      <= 1'b0;
            warnReg     <= 1'b0;
            authReg     <= 1'b0;
            evacReg     <= 1'b0;
            lockNeedReg <= 1'b0;
            clearOutReg <= 1'b0;
            escCnt      <= '0;
            ackedReg    <= 1'b0;
            holdCnt     <= '0;
        end else begin
            stateReg    <= nextState;
            zoneFireReg <= fireNext;
            zoneLockReg <= lockNext;
            zoneMedReg  <= medNext;
            stormReg    <= stormNext;
            hsReg       <= hsNext;
            noEmReg     <= (nextState == IDLE) || (nextState == TEST) || (nextState == CLEARING);
            nonSpecReg  <= (nextState == SUSPECT);
            confReg     <= confNext;
            escReg      <= (nextState == ESCALATED);
            authReg     <= confNext;
            warnReg     <= confNext & ((|fireNext) | (|lockNext) | stormNext | hsNext);
            evacReg     <= confNext & ((|fireNext) | stormNext);
            lockNeedReg <= confNext & (|lockNext);
            clearOutReg <= (nextState == CLEARING);

            if (nextState == CLEARING) begin
                escCnt   <= '0;
                ackedReg <= 1'b0;
            end else if (stateReg == CONFIRMED) begin
                if (bus.ack || ackedReg) ackedReg <= 1'b1;
                else                     escCnt   <= escCnt + 1'b1;
            end

            if ((stateReg == CLEARING) && (nextState == CLEARING)) holdCnt <= holdCnt + 1'b1;
            else                                                   holdCnt <= '0;
        end
    end

    assign bus.zone_fire              = zoneFireReg;
    assign bus.zone_lockdown          = zoneLockReg;
    assign bus.zone_medical           = zoneMedReg;
    assign bus.storm                  = stormReg;
    assign bus.heightened_security    = hsReg;
    assign bus.no_emergency           = noEmReg;
    assign bus.non_specific_emergency = nonSpecReg;
    assign bus.confirmed_emergency    = confReg;
    assign bus.escalated              = escReg;
    assign bus.warn_students          = warnReg;
    assign bus.authority_contacted    = authReg;
    assign bus.need_evacuation        = evacReg;
    assign bus.lockdown_needed        = lockNeedReg;
    assign bus.all_clear_out          = clearOutReg;
    assign bus.state                  = stateReg;
endmodule

// File: tb/tb_safety_zone_monitor.sv
// Scoreboard bench for safety_zone_monitor: a cycle-level reference model predicts every
// output vector, a monitor compares it one edge later against the DUT.
module tb_safety_zone_monitor;
    localparam int NZ   = 4;
    localparam int DEB  = 8;
    localparam int ESC  = 1000;
    localparam int HOLD = 16;
    localparam int NRAW = 5 * NZ + 2;
    localparam int OW   = 3 * NZ + 14;

    localparam int S_IDLE = 0, S_SUSP = 1, S_CONF = 2, S_ESCD = 3, S_TEST = 4, S_CLR = 5;

    typedef struct {
        int            cyc;
        logic [OW-1:0] vec;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    safety_zone_if #(.NUM_ZONES(NZ)) szIf ();

    safety_zone_monitor #(
        .NUM_ZONES(NZ), .DEBOUNCE_CYCLES(DEB), .ESCALATE_CYCLES(ESC), .CLEAR_HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(szIf)
    );

    always #5 clk = ~clk;

    // stimulus values held by the bench
    logic [NZ-1:0] mt, ln, cs, up, mr;
    logic          rain, loc, tst, clr, ackIn;

    // reference model state
    int        runLen [NRAW];
    int        mState;
    bit [NZ-1:0] mFire, mLock, mMed;
    bit        mStorm, mHs;
    int        escCount;
    bit        acked;
    int        clearLeft;

    expT  expQ[$];
    int   cycle = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   stimDone = 1'b0;
    int   drainLeft = 10;

    function automatic logic [OW-1:0] packExpected();
        bit conf, warn, evac, lockN, noEm;
        conf  = (mState == S_CONF) || (mState == S_ESCD);
        noEm  = (mState == S_IDLE) || (mState == S_TEST) || (mState == S_CLR);
        warn  = conf && ((mFire != 0) || (mLock != 0) || mStorm || mHs);
        evac  = conf && ((mFire != 0) || mStorm);
        lockN = conf && (mLock != 0);
        return {mFire, mLock, mMed, mStorm, mHs, noEm, (mState == S_SUSP), conf,
                (mState == S_ESCD), warn, conf, evac, lockN, (mState == S_CLR), 3'(mState)};
    endfunction

    function automatic logic [OW-1:0] dutVec();
        return {szIf.zone_fire, szIf.zone_lockdown, szIf.zone_medical, szIf.storm,
                szIf.heightened_security, szIf.no_emergency, szIf.non_specific_emergency,
                szIf.confirmed_emergency, szIf.escalated, szIf.warn_students,
                szIf.authority_contacted, szIf.need_evacuation, szIf.lockdown_needed,
                szIf.all_clear_out, szIf.state};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NRAW; i++) runLen[i] = 0;
        mState = S_IDLE;
        mFire = '0; mLock = '0; mMed = '0; mStorm = 1'b0; mHs = 1'b0;
        escCount = 0; acked = 1'b0; clearLeft = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT will sample at that edge.
    task automatic modelStep();
        bit raw [NRAW];
        bit f [NRAW];
        bit [NZ-1:0] fire, lock, med;
        bit anyTrig, stormC, anyC;
        int nxt;
        for (int z = 0; z < NZ; z++) begin
            raw[z] = mt[z]; raw[NZ+z] = ln[z]; raw[2*NZ+z] = cs[z];
            raw[3*NZ+z] = up[z]; raw[4*NZ+z] = mr[z];
        end
        raw[5*NZ] = rain; raw[5*NZ+1] = loc;
        for (int i = 0; i < NRAW; i++) f[i] = (runLen[i] >= DEB);
        anyTrig = 1'b0;
        for (int z = 0; z < NZ; z++) begin
            bit t;
            t       = f[z] | f[NZ+z];
            anyTrig = anyTrig | t;
            fire[z] = t & f[2*NZ+z];
            lock[z] = f[5*NZ+1] & (f[NZ+z] | f[3*NZ+z]);
            med[z]  = f[4*NZ+z];
        end
        stormC = anyTrig & f[5*NZ];
        anyC   = (fire != 0) || (lock != 0) || (med != 0) || stormC;

        nxt = mState;
        case (mState)
            S_IDLE: begin
                if (anyC) nxt = tst ? S_TEST : S_CONF;
                else if (anyTrig) nxt = S_SUSP;
            end
            S_SUSP: begin
                if (clr) nxt = S_CLR;
                else if (anyC) nxt = tst ? S_TEST : S_CONF;
            end
            S_CONF: begin
                if (clr) nxt = S_CLR;
                else if (ackIn || acked) acked = 1'b1;
                else begin
                    escCount++;
                    if (escCount >= ESC) nxt = S_ESCD;
                end
            end
            S_ESCD: if (clr) nxt = S_CLR;
            S_TEST: if (clr || !tst) nxt = S_CLR;
            S_CLR: begin
                clearLeft--;
                if (clearLeft == 0) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase

        if (nxt == S_CLR && mState != S_CLR) clearLeft = HOLD;

        if (nxt == S_CLR) begin
            mFire = '0; mLock = '0; mMed = '0; mStorm = 1'b0; mHs = 1'b0;
            escCount = 0; acked = 1'b0;
        end else begin
            if (nxt == S_SUSP || nxt == S_CONF || nxt == S_ESCD || nxt == S_TEST) begin
                mFire  = mFire | fire;
                mLock  = mLock | lock;
                mMed   = mMed | med;
                mStorm = mStorm | stormC;
            end
            if (f[5*NZ+1]) mHs = 1'b1;
        end

        for (int i = 0; i < NRAW; i++) begin
            if (nxt == S_CLR || mState == S_CLR || !raw[i]) runLen[i] = 0;
            else if (runLen[i] < DEB) runLen[i] = runLen[i] + 1;
        end
        mState = nxt;
    endtask

    task automatic zeroInputs();
        mt = '0; ln = '0; cs = '0; up = '0; mr = '0;
        rain = 1'b0; loc = 1'b0; tst = 1'b0; clr = 1'b0; ackIn = 1'b0;
    endtask

    task automatic applyInputs();
        szIf.manual_trigger  = mt;
        szIf.loud_noise      = ln;
        szIf.carbon_sensor   = cs;
        szIf.unwanted_person = up;
        szIf.medical_report  = mr;
        szIf.is_raining      = rain;
        szIf.local_alert     = loc;
        szIf.is_system_test  = tst;
        szIf.all_clear       = clr;
        szIf.ack             = ackIn;
    endtask

    // Called at a falling edge; each iteration covers exactly one rising edge.
    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            expT e;
            applyInputs();
            modelStep();
            cycle++;
            e.cyc = cycle;
            e.vec = packExpected();
            expQ.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic clearAll();
        zeroInputs();
        clr = 1'b1;
        runCycles(1);
        clr = 1'b0;
        runCycles(HOLD + 3);
    endtask

    task automatic midReset();
        expT e;
        @(posedge clk);
        #3;
        rst = 1'b1;
        zeroInputs();
        applyInputs();
        modelReset();
        e.cyc = -1;
        e.vec = packExpected();
        expQ.push_back(e);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [NZ-1:0] randMask();
        logic [NZ-1:0] m;
        for (int z = 0; z < NZ; z++) m[z] = ($urandom_range(0, 4) == 0);
        return m;
    endfunction

    initial begin : stimulus
        expT e;
        zeroInputs();
        applyInputs();
        modelReset();
        e.cyc = 0;
        e.vec = packExpected();
        expQ.push_back(e);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        runCycles(3);
        $display("scenario reset_idle issued up to cycle %0d", cycle);

        mt[1] = 1'b1;
        runCycles(DEB - 1);
        mt[1] = 1'b0;
        runCycles(5);
        $display("scenario short_pull issued up to cycle %0d", cycle);

        mt = 4'b0100; cs = 4'b0100;
        runCycles(9 + ESC + 2);
        clearAll();
        $display("scenario fire_escalate issued up to cycle %0d", cycle);

        mt = 4'b0100; cs = 4'b0100;
        runCycles(9 + 500);
        ackIn = 1'b1; runCycles(1); ackIn = 1'b0;
        runCycles(600);
        clearAll();
        $display("scenario fire_ack issued up to cycle %0d", cycle);

        mt = 4'b0100; cs = 4'b0100;
        runCycles(9 + ESC - 1);
        ackIn = 1'b1; runCycles(1); ackIn = 1'b0;
        runCycles(20);
        clearAll();
        $display("scenario ack_at_terminal issued up to cycle %0d", cycle);

        tst = 1'b1; mr = 4'b0001;
        runCycles(12);
        tst = 1'b0; mr = 4'b0000;
        runCycles(HOLD + 3);
        $display("scenario system_test issued up to cycle %0d", cycle);

        loc = 1'b1;
        runCycles(12);
        up = 4'b1000;
        runCycles(12);
        clearAll();
        $display("scenario lockdown issued up to cycle %0d", cycle);

        mt = 4'b0001;
        runCycles(DEB + 2);
        rain = 1'b1;
        runCycles(DEB);
        clr = 1'b1; runCycles(1); clr = 1'b0;
        zeroInputs();
        runCycles(HOLD + 3);
        $display("scenario storm_vs_all_clear issued up to cycle %0d", cycle);

        mt = 4'b0100; cs = 4'b0100;
        runCycles(9 + ESC + 3);
        midReset();
        runCycles(4);
        $display("scenario reset_in_escalated issued up to cycle %0d", cycle);

        for (int s = 0; s < 250; s++) begin
            int len;
            len  = $urandom_range(1, 24);
            mt   = randMask(); ln = randMask(); cs = randMask();
            up   = randMask(); mr = randMask();
            rain = ($urandom_range(0, 3) == 0);
            loc  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) tst = ~tst;
            for (int c = 0; c < len; c++) begin
                clr   = ($urandom_range(0, 29) == 0);
                ackIn = ($urandom_range(0, 19) == 0);
                runCycles(1);
            end
        end
        zeroInputs();
        runCycles(2);
        $display("scenario random issued up to cycle %0d", cycle);

        stimDone = 1'b1;
    end

    initial begin : monitor
        expT e;
        logic [OW-1:0] got;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                got = dutVec();
                compared++;
                if (got !== e.vec) begin
                    mismatched++;
                    $display("FAIL outputs at cycle %0d: got %h (state %0d) required %h (state %0d)",
                             e.cyc, got, got[2:0], e.vec, e.vec[2:0]);
                end
            end
            if (stimDone) begin
                if (expQ.size() == 0) break;
                drainLeft--;
                if (drainLeft == 0) begin
                    mismatched++;
                    $display("FAIL drain: %0d expected vectors left unchecked, required 0", expQ.size());
                    break;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
